// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Package : eth_pkg
// Purpose : Shared definitions for the Ethernet receive path: the receive
//           FSM state type, preamble/SFD byte values, the CRC-32 bit-serial
//           update function shared with the TX generator, bit-reversal helpers,
//           and the bit positions inside the o_err status vector.
// Revision: 1.0  initial release
// ============================================================================
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Bytes held back so the trailing FCS never reaches the output.
  localparam logic [2:0]  FCS_DELAY     = 3'd5;

  // o_err = {too_long, runt, phy_err, fcs_bad}
  localparam int ERR_FCS_BAD  = 0;
  localparam int ERR_PHY      = 1;
  localparam int ERR_RUNT     = 2;
  localparam int ERR_TOO_LONG = 3;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  // MSB-first CRC-32 update over one byte; d[7] is shifted in first, so
  // callers pass bitrev8(byte) to present the wire's first bit first.
  function automatic logic [31:0] crc32_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ CRC32_POLY;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_fcs_delay5.sv
`default_nettype none
// ============================================================================
// Module  : eth_fcs_delay5
// Purpose : Five-byte shift delay line. Holds the most recent five frame
//           bytes so the top can recognise the final four as the FCS.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           clr_i         empty the line (occupancy -> 0)
//           push_i        shift data_i in as the newest byte
//           data_i[7:0]   byte to push
//           head_o[7:0]   oldest byte currently held (0 when empty)
//           fcs_o[31:0]   four youngest bytes, oldest of them in bits [7:0]
//           count_o[2:0]  occupancy, saturates at 5
// Revision: 1.0  initial release
// ============================================================================
module eth_fcs_delay5 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic [31:0] fcs_o,
  output logic [2:0] count_o
);

  // slot 0 (bits [7:0]) is the newest byte, slot 4 the oldest
  logic [39:0] slots_q;
  logic [2:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
      count_q <= 3'd0;
    end else if (clr_i) begin
      count_q <= 3'd0;
    end else if (push_i) begin
      slots_q <= {slots_q[31:0], data_i};
      if (count_q != 3'd5) count_q <= count_q + 3'd1;
    end
  end

  always_comb begin
    head_o = 8'h00;
    case (count_q)
      3'd1:    head_o = slots_q[7:0];
      3'd2:    head_o = slots_q[15:8];
      3'd3:    head_o = slots_q[23:16];
      3'd4:    head_o = slots_q[31:24];
      3'd5:    head_o = slots_q[39:32];
      default: head_o = 8'h00;
    endcase
  end

  // FCS arrives LSB byte first, so the oldest of the four is the low byte.
  assign fcs_o   = {slots_q[7:0], slots_q[15:8], slots_q[23:16], slots_q[31:24]};
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module  : eth_rx_fcs_check
// Purpose : Receive-side FCS checker. Strips preamble/SFD and FCS from an
//           802.3 byte stream, streams the frame bytes out, tags the final
//           byte with FCS/length/PHY-error status and keeps saturating
//           good/bad frame counters.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           i_rx_dv             frame envelope, low = inter-frame gap
//           i_rx_valid          byte strobe, taken when i_rx_dv & i_rx_valid
//           i_rx_data[7:0]      received byte, bit 0 first on the wire
//           i_rx_er             PHY error flag for the taken byte
//           o_data[7:0]         frame byte with FCS removed
//           o_valid             o_data strobe
//           o_last              final frame byte (with o_valid)
//           o_fcs_ok            FCS matched (with o_last)
//           o_err[3:0]          {too_long, runt, phy_err, fcs_bad} (with o_last)
//           o_drop              frame discarded without output
//           o_cnt_good/o_cnt_bad saturating frame statistics
// Revision: 1.0  initial release
// ============================================================================
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx_dv,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_er,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_fcs_ok,
  output logic [3:0]       o_err,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_cnt_good,
  output logic [CNT_W-1:0] o_cnt_bad
);

  localparam int LEN_W = $clog2(MAX_FRAME + 2);

  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             phy_q, phy_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             fcs_ok_q, fcs_ok_d;
  logic [3:0]       err_q, err_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_good_q, cnt_bad_q;

  logic             w_take;
  logic             w_dl_clr, w_dl_push;
  logic [7:0]       w_dl_head;
  logic [31:0]      w_dl_fcs;
  logic [2:0]       w_dl_count;
  logic [31:0]      w_crc_head;
  logic             w_fcs_bad;
  logic             w_phy_new;
  logic [LEN_W-1:0] w_len_inc;

  assign w_take     = i_rx_dv & i_rx_valid;
  // CRC as it would be once the oldest held byte is folded in; used both for
  // normal streaming and for the final FCS comparison.
  assign w_crc_head = crc32_next(crc_q, bitrev8(w_dl_head));
  assign w_fcs_bad  = (~bitrev32(w_crc_head)) != w_dl_fcs;
  assign w_phy_new  = phy_q | i_rx_er;
  assign w_len_inc  = len_q + LEN_W'(1);

  eth_fcs_delay5 u_delay (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_dl_clr),
    .push_i  (w_dl_push),
    .data_i  (i_rx_data),
    .head_o  (w_dl_head),
    .fcs_o   (w_dl_fcs),
    .count_o (w_dl_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      crc_q    <= CRC32_INIT;
      len_q    <= '0;
      phy_q    <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      fcs_ok_q <= 1'b0;
      err_q    <= 4'h0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      phy_q    <= phy_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      fcs_ok_q <= fcs_ok_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    phy_d     = phy_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    fcs_ok_d  = 1'b0;
    err_d     = 4'h0;
    drop_d    = 1'b0;
    w_dl_clr  = 1'b0;
    w_dl_push = 1'b0;

    case (state_q)
      // IDLE treats the first byte of the envelope exactly like a preamble byte.
      ST_IDLE, ST_PREAMBLE: begin
        if (!i_rx_dv) begin
          state_d = ST_IDLE;
        end else if (w_take) begin
          if (i_rx_data == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
          end else if (i_rx_data == SFD_BYTE) begin
            state_d  = ST_DATA;
            crc_d    = CRC32_INIT;
            len_d    = '0;
            phy_d    = 1'b0;
            w_dl_clr = 1'b1;
          end else begin
            state_d = ST_DROP;
            drop_d  = 1'b1;
          end
        end else begin
          state_d = ST_PREAMBLE;
        end
      end

      ST_DATA: begin
        if (!i_rx_dv) begin
          state_d  = ST_IDLE;
          w_dl_clr = 1'b1;
          if (w_dl_count == FCS_DELAY) begin
            valid_d                = 1'b1;
            last_d                 = 1'b1;
            data_d                 = w_dl_head;
            err_d[ERR_FCS_BAD]     = w_fcs_bad;
            err_d[ERR_PHY]         = phy_q;
            err_d[ERR_RUNT]        = len_q < LEN_W'(MIN_FRAME);
            fcs_ok_d               = ~w_fcs_bad;
          end else begin
            drop_d = 1'b1;
          end
        end else if (w_take) begin
          len_d = w_len_inc;
          if (len_q == LEN_W'(MAX_FRAME)) begin
            // This byte exceeds the limit: close the frame on the held oldest
            // byte and discard the rest of the envelope.
            state_d                = ST_DROP;
            w_dl_clr               = 1'b1;
            valid_d                = 1'b1;
            last_d                 = 1'b1;
            data_d                 = w_dl_head;
            err_d[ERR_FCS_BAD]     = 1'b1;
            err_d[ERR_PHY]         = w_phy_new;
            err_d[ERR_RUNT]        = w_len_inc < LEN_W'(MIN_FRAME);
            err_d[ERR_TOO_LONG]    = 1'b1;
          end else begin
            phy_d     = w_phy_new;
            w_dl_push = 1'b1;
            if (w_dl_count == FCS_DELAY) begin
              valid_d = 1'b1;
              data_d  = w_dl_head;
              crc_d   = w_crc_head;
            end
          end
        end
      end

      ST_DROP: begin
        if (!i_rx_dv) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Statistics follow the registered status by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
    end else if (valid_q && last_q) begin
      if (err_q == 4'h0) begin
        if (cnt_good_q != {CNT_W{1'b1}}) cnt_good_q <= cnt_good_q + CNT_W'(1);
      end else begin
        if (cnt_bad_q != {CNT_W{1'b1}}) cnt_bad_q <= cnt_bad_q + CNT_W'(1);
      end
    end else if (drop_q) begin
      if (cnt_bad_q != {CNT_W{1'b1}}) cnt_bad_q <= cnt_bad_q + CNT_W'(1);
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_fcs_ok   = fcs_ok_q;
  assign o_err      = err_q;
  assign o_drop     = drop_q;
  assign o_cnt_good = cnt_good_q;
  assign o_cnt_bad  = cnt_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_fcs_check.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_rx_fcs_check
// Purpose : Self-checking bench for eth_rx_fcs_check. Frames are built as
//           byte queues, driven with random strobe gaps, and the collected
//           output is compared with a frame-level reference model that uses
//           the reflected (LSB-first) CRC-32 formulation.
// Revision: 1.0  initial release
// ============================================================================
module tb_eth_rx_fcs_check;
  import eth_pkg::*;

  localparam int MIN_F = 64;
  localparam int MAX_F = 1518;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_dv, rx_valid, rx_er;
  logic [7:0]    rx_data;
  logic [7:0]    o_data;
  logic          o_valid, o_last, o_fcs_ok, o_drop;
  logic [3:0]    o_err;
  logic [CW-1:0] o_cnt_good, o_cnt_bad;

  always #5 clk = ~clk;

  eth_rx_fcs_check #(.MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_dv    (rx_dv),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .i_rx_er    (rx_er),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_fcs_ok   (o_fcs_ok),
    .o_err      (o_err),
    .o_drop     (o_drop),
    .o_cnt_good (o_cnt_good),
    .o_cnt_bad  (o_cnt_bad)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  logic [7:0] got_q[$];
  int         got_nlast, got_last_pos, got_ndrop;
  logic [3:0] got_err;
  logic       got_ok;

  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back(o_data);
      if (o_last) begin
        got_nlast++;
        got_last_pos = got_q.size() - 1;
        got_err      = o_err;
        got_ok       = o_fcs_ok;
      end
    end
    if (o_drop) got_ndrop++;
  end

  task automatic clear_mon();
    got_q.delete();
    got_nlast    = 0;
    got_last_pos = -1;
    got_ndrop    = 0;
    got_err      = 4'h0;
    got_ok       = 1'b0;
  endtask

  // ---------------- stimulus and reference model ----------------
  logic [7:0] tx_b[$];
  bit         tx_e[$];
  logic [7:0] exp_q[$];
  int         exp_last, exp_drop, exp_good, exp_bad;
  logic [3:0] exp_err;
  logic       exp_ok;

  // Reflected CRC-32 (poly 0xEDB88320), FCS = ~crc.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int pre, input int n, input bit seq, input logic [31:0] fcs_x);
    logic [31:0] c, f;
    logic [7:0]  b;
    tx_b.delete();
    tx_e.delete();
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < pre; k++) begin tx_b.push_back(8'h55); tx_e.push_back(1'b0); end
    tx_b.push_back(8'hD5); tx_e.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      b = seq ? 8'(k) : 8'($urandom);
      tx_b.push_back(b);
      tx_e.push_back(1'b0);
      c = ref_crc(c, b);
    end
    f = ~c ^ fcs_x;
    for (int j = 0; j < 4; j++) begin tx_b.push_back(f[8*j +: 8]); tx_e.push_back(1'b0); end
  endtask

  task automatic model();
    int          i, p, n, lim, nout;
    bit          phy, bad;
    logic [31:0] c, rxf;
    exp_q.delete();
    exp_last = 0; exp_drop = 0; exp_err = 4'h0; exp_ok = 1'b0;
    i = 0;
    while (i < tx_b.size() && tx_b[i] == 8'h55) i++;
    if (i < tx_b.size()) begin
      if (tx_b[i] != 8'hD5) begin
        exp_drop = 1;
      end else begin
        p = i + 1;
        n = tx_b.size() - p;
        if (n < 5) begin
          exp_drop = 1;
        end else begin
          lim  = (n > MAX_F) ? MAX_F + 1 : n;
          nout = (n > MAX_F) ? MAX_F - 4 : n - 4;
          phy  = 1'b0;
          for (int k = 0; k < lim; k++) phy = phy | tx_e[p+k];
          c = 32'hFFFF_FFFF;
          for (int k = 0; k < nout; k++) begin
            exp_q.push_back(tx_b[p+k]);
            c = ref_crc(c, tx_b[p+k]);
          end
          exp_last = 1;
          if (n > MAX_F) begin
            exp_err = {1'b1, 1'(MAX_F + 1 < MIN_F), phy, 1'b1};
            exp_ok  = 1'b0;
          end else begin
            rxf     = {tx_b[p+n-1], tx_b[p+n-2], tx_b[p+n-3], tx_b[p+n-4]};
            bad     = (rxf != ~c);
            exp_err = {1'b0, 1'(n < MIN_F), phy, bad};
            exp_ok  = !bad;
          end
        end
      end
    end
    if (exp_last != 0) begin
      if (exp_err == 4'h0) exp_good++; else exp_bad++;
    end
    if (exp_drop != 0) exp_bad++;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit e);
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    rx_er    = e;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_er    = 1'b0;
  endtask

  // Gap with random strobes while dv is low; these must be ignored.
  task automatic idle_gap(input int n);
    rx_dv = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      rx_er    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_er    = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    int mism;
    clear_mon();
    rx_dv = 1'b1;
    for (int k = 0; k < tx_b.size(); k++) drive_byte(tx_b[k], tx_e[k]);
    idle_gap(6);
    model();
    chk({tag, ":nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    mism = 0;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) mism++;
    chk({tag, ":byte_mismatches"}, 32'(mism), 32'd0);
    chk({tag, ":nlast"}, 32'(got_nlast), 32'(exp_last));
    chk({tag, ":last_pos"}, 32'(got_last_pos), (exp_last != 0) ? 32'(exp_q.size() - 1) : 32'hFFFF_FFFF);
    chk({tag, ":err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ":fcs_ok"}, 32'(got_ok), 32'(exp_ok));
    chk({tag, ":drop"}, 32'(got_ndrop), 32'(exp_drop));
    chk({tag, ":cnt_good"}, 32'(o_cnt_good), 32'(exp_good));
    chk({tag, ":cnt_bad"}, 32'(o_cnt_bad), 32'(exp_bad));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [71:0] ascii;
    logic [31:0] c_pkg, c_ref;
    logic [7:0]  ch;
    int          pre, n;

    rst = 1'b1; rx_dv = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_er = 1'b0;
    exp_good = 0; exp_bad = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst:valid", 32'(o_valid), 32'd0);
    chk("rst:flags", 32'({o_last, o_fcs_ok, o_drop, o_err}), 32'd0);
    chk("rst:data", 32'(o_data), 32'd0);
    chk("rst:cnt_good", 32'(o_cnt_good), 32'd0);
    chk("rst:cnt_bad", 32'(o_cnt_bad), 32'd0);
    rst = 1'b0;
    idle_gap(3);

    // CRC check value over ASCII "123456789"
    ascii = "123456789";
    c_pkg = CRC32_INIT;
    c_ref = 32'hFFFF_FFFF;
    for (int k = 0; k < 9; k++) begin
      ch    = ascii[8*(8-k) +: 8];
      c_pkg = crc32_next(c_pkg, bitrev8(ch));
      c_ref = ref_crc(c_ref, ch);
    end
    chk("crc_pkg", ~bitrev32(c_pkg), 32'hCBF4_3926);
    chk("crc_ref", ~c_ref, 32'hCBF4_3926);

    build(7, 60, 1'b1, 32'h0);          run_frame("good60");
    build(7, 60, 1'b1, 32'h1);          run_frame("fcsbad60");
    build(7, 20, 1'b1, 32'h0);          run_frame("runt20");

    tx_b = {8'h55, 8'hD5, 8'hAA, 8'hBB};
    tx_e = {1'b0, 1'b0, 1'b0, 1'b0};
    run_frame("short2");

    build(7, 1596, 1'b0, 32'h0);        run_frame("toolong");

    build(7, 60, 1'b1, 32'h0);
    tx_e[8+10] = 1'b1;
    run_frame("phyerr");

    tx_b = {8'h55, 8'h55, 8'h12, 8'h33, 8'h44, 8'h55};
    tx_e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_frame("badpre");

    // Reset in the middle of the data phase
    build(7, 40, 1'b1, 32'h0);
    clear_mon();
    rx_dv = 1'b1;
    for (int k = 0; k < 8 + 20; k++) drive_byte(tx_b[k], tx_e[k]);
    rst   = 1'b1;
    rx_dv = 1'b0;
    #1;
    chk("rstmid:valid", 32'(o_valid), 32'd0);
    chk("rstmid:data", 32'(o_data), 32'd0);
    chk("rstmid:cnt_good", 32'(o_cnt_good), 32'd0);
    chk("rstmid:cnt_bad", 32'(o_cnt_bad), 32'd0);
    exp_good = 0;
    exp_bad  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_gap(4);
    build(7, 60, 1'b0, 32'h0);          run_frame("after_rst");

    // Randomised frames
    for (int r = 0; r < 14; r++) begin
      pre = $urandom_range(1, 8);
      n   = $urandom_range(0, 90);
      build(pre, n, 1'b0, ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
      if ($urandom_range(0, 4) == 0) tx_e[$urandom_range(0, tx_b.size() - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) tx_b[$urandom_range(0, pre - 1)] = 8'h5A;
      run_frame("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
